ps2_rx_frame: RTL

Deserializes the raw PS/2 keyboard line pair (ps2_clk, ps2_data) into validated 8-bit scan-code bytes. Drives the key_en / key_data pair that the keycode recognizer in the game system consumes, one single-cycle key_en pulse per good frame. Sits between the board PS/2 pins and the system top level, in the clk domain.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_filter.sv | 55 +++++
 rtl/ps2_rx_frame.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encoding, frame bit
// constants and default timing parameters.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned DEF_FILTER_LEN     = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 50000;
    localparam int unsigned FILTER_CNT_W       = 4;
    localparam int unsigned BYTE_W             = 8;

    // Odd parity over data plus parity bit must come out as 1.
    function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus optional run-length debounce for one PS/2 pin.
// Produces the filtered level and a registered one-cycle falling-edge strobe.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
    parameter bit          BYPASS     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_level;
    logic                    r_prev;
    logic                    r_fall;
    logic [FILTER_CNT_W-1:0] r_cnt;

    // Level only flips after FILTER_LEN consecutive disagreeing samples;
    // in bypass mode the stage just re-times sync2 to keep path depth equal.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_prev  <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_prev  <= r_level;
            r_fall  <= r_prev & ~r_level;
            if (BYPASS) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == FILTER_CNT_W'(FILTER_LEN - 1)) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + FILTER_CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Emits key_en per good byte, frame_err on bad frame or timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic              key_en,
    output logic [BYTE_W-1:0] key_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic w_strobe;
    logic w_data;
    logic w_clk_level_unused;
    logic w_data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .BYPASS(1'b0)) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .i_pin   (ps2_clk),
        .o_level (w_clk_level_unused),
        .o_fall  (w_strobe)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .BYPASS(1'b1)) u_data_sync (
        .clk     (clk),
        .reset   (reset),
        .i_pin   (ps2_data),
        .o_level (w_data),
        .o_fall  (w_data_fall_unused)
    );

    ps2_state_e        r_state,     w_state_nxt;
    logic [2:0]        r_bit_cnt,   w_bit_cnt_nxt;
    logic [BYTE_W-1:0] r_shift,     w_shift_nxt;
    logic              r_parity,    w_parity_nxt;
    logic [TMO_W-1:0]  r_tmo,       w_tmo_nxt;
    logic              r_key_en,    w_key_en_nxt;
    logic [BYTE_W-1:0] r_key_data,  w_key_data_nxt;
    logic              r_frame_err, w_frame_err_nxt;
    logic              r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tmo       <= '0;
            r_key_en    <= 1'b0;
            r_key_data  <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_parity    <= w_parity_nxt;
            r_tmo       <= w_tmo_nxt;
            r_key_en    <= w_key_en_nxt;
            r_key_data  <= w_key_data_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_parity_nxt    = r_parity;
        w_tmo_nxt       = '0;
        w_key_en_nxt    = 1'b0;
        w_key_data_nxt  = r_key_data;
        w_frame_err_nxt = 1'b0;

        if (r_state != ST_IDLE && !w_strobe) begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (w_strobe && w_data == START_BIT) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (w_strobe) begin
                    w_shift_nxt = {w_data, r_shift[BYTE_W-1:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_strobe) begin
                    w_parity_nxt = w_data;
                    w_state_nxt  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_strobe) begin
                    if (w_data == STOP_BIT && odd_parity_ok(r_shift, r_parity)) begin
                        w_key_data_nxt = r_shift;
                        w_key_en_nxt   = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A strobe in the same cycle keeps the counter cleared, so it wins.
        if (r_state != ST_IDLE && !w_strobe && r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt     = ST_IDLE;
            w_frame_err_nxt = 1'b1;
            w_tmo_nxt       = '0;
        end
    end

    assign key_en    = r_key_en;
    assign key_data  = r_key_data;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule
